str_fifo: RTL and testbench

Synchronous valid/ready stream FIFO with a depth of 2**AW words. It sits between a stream producer (upstream, drives `s_*`) and a stream consumer (downstream, accepts `m_*`) on the same clock. It decouples their backpressure and absorbs bursts without losing or reordering words. Reads are first-word-fall-through: the oldest stored word is always presented on `m_tdata` while `m_tvalid` is high.

---
 rtl/str_fifo.sv | 100 ++++++++++
 tb/tb_str_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/str_fifo.sv
// str_fifo: synchronous valid/ready stream FIFO, first-word-fall-through.
// Depth is 2**AW words. Both handshake flags are registered, so neither
// s_tready nor m_tvalid has a combinational path from any input.
// Optional feature: define STR_FIFO_CNT_EN to add the registered m_tcount
// occupancy output (AW+1 bits, 0..DEPTH).
module str_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [DW-1:0] s_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [DW-1:0] m_tdata
`ifdef STR_FIFO_CNT_EN
  ,
  output logic [AW:0]   m_tcount
`endif
);

  localparam int DEPTH = 1 << AW;

  // Storage is plain data: never reset, only written on a push.
  logic [DW-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr_nxt;
  logic [AW:0] rd_ptr_nxt;

  logic push;
  logic pop;

  // Full: same slot, opposite wrap bit.
  function automatic logic is_full(input logic [AW:0] wp, input logic [AW:0] rp);
    return (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  endfunction

  // Empty: pointers identical.
  function automatic logic is_empty(input logic [AW:0] wp, input logic [AW:0] rp);
    return wp == rp;
  endfunction

  // Handshakes use only the registered flags, so a pop while full cannot
  // make room for a push in the same cycle, and a push into an empty FIFO
  // is not bypassed to the output.
  assign push = s_tvalid && s_tready;
  assign pop  = m_tvalid && m_tready;

  // Next pointer values; the flags below are computed from these so that
  // they describe the state seen during the following cycle.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (push) wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, 1'b1};
    if (pop)  rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, 1'b1};
  end

  // Pointer and flag registers; reset forces the FIFO empty and closes
  // the input for one cycle regardless of any handshake in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      s_tready <= 1'b0;
      m_tvalid <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      s_tready <= !is_full(wr_ptr_nxt, rd_ptr_nxt);
      m_tvalid <= !is_empty(wr_ptr_nxt, rd_ptr_nxt);
    end
  end

  // Word array write on each accepted upstream word.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_tdata;
  end

  // Oldest word falls through to the output without a register stage.
  assign m_tdata = mem[rd_ptr[AW-1:0]];

`ifdef STR_FIFO_CNT_EN
  // Occupancy counter: up on push-only, down on pop-only, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tcount <= '0;
    end else if (push && !pop) begin
      m_tcount <= m_tcount + {{AW{1'b0}}, 1'b1};
    end else if (pop && !push) begin
      m_tcount <= m_tcount - {{AW{1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_str_fifo.sv
// tb_str_fifo: directed table-driven bench for str_fifo (DW=8, AW=2),
// followed by hand-written boundary sequences and a queue-model run with
// random valid/ready. Count checks are included when STR_FIFO_CNT_EN is set.
module tb_str_fifo;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
`ifdef STR_FIFO_CNT_EN
  logic [AW:0]   m_tcount;
`endif

  int checks = 0;
  int errors = 0;

  str_fifo #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata)
`ifdef STR_FIFO_CNT_EN
    ,
    .m_tcount (m_tcount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          sv;
    logic [DW-1:0] d;
    logic          mr;
    logic          e_rdy;
    logic          e_vld;
    logic [DW-1:0] e_data;
    int            e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic sv, input logic [DW-1:0] d,
                              input logic mr, input logic e_rdy, input logic e_vld,
                              input logic [DW-1:0] e_data, input int e_cnt);
    vec_t v;
    v.rst = r; v.sv = sv; v.d = d; v.mr = mr;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cnt(input string name, input int exp);
`ifdef STR_FIFO_CNT_EN
    check(name, int'(m_tcount), exp);
`endif
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic sv, input logic [DW-1:0] d, input logic mr);
    rst = r; s_tvalid = sv; s_tdata = d; m_tready = mr;
  endtask

  logic [DW-1:0] q[$];
  logic          sv_r;
  logic          mr_r;
  logic [DW-1:0] d_r;
  logic          do_push;
  logic          do_pop;

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0);

    // Reset, fill to full, refused push while full, drain in order.
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 8'h11, 0, 1, 1, 8'h11, 1));
    tbl.push_back(mk(0, 1, 8'h22, 0, 1, 1, 8'h11, 2));
    tbl.push_back(mk(0, 1, 8'h33, 0, 1, 1, 8'h11, 3));
    tbl.push_back(mk(0, 1, 8'h44, 0, 0, 1, 8'h11, 4));
    tbl.push_back(mk(0, 1, 8'h99, 0, 0, 1, 8'h11, 4));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h22, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h33, 2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h44, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0));
    // Two stored words, then eight cycles of simultaneous push and pop.
    tbl.push_back(mk(0, 1, 8'hB1, 0, 1, 1, 8'hB1, 1));
    tbl.push_back(mk(0, 1, 8'hB2, 0, 1, 1, 8'hB1, 2));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, 8'(8'hA0 + i), 1, 1, 1,
                       (i == 0) ? 8'hB2 : 8'(8'hA0 + i - 1), 2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'hA7, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 0));

    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].sv, tbl[i].d, tbl[i].mr);
      step();
      check($sformatf("vec%0d s_tready", i), int'(s_tready), int'(tbl[i].e_rdy));
      check($sformatf("vec%0d m_tvalid", i), int'(m_tvalid), int'(tbl[i].e_vld));
      if (tbl[i].e_vld)
        check($sformatf("vec%0d m_tdata", i), int'(m_tdata), int'(tbl[i].e_data));
      check_cnt($sformatf("vec%0d m_tcount", i), tbl[i].e_cnt);
    end

    // Full boundary: a pop while full must not admit the waiting word.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 8'(8'hC0 + i), 0);
      step();
    end
    check("full s_tready", int'(s_tready), 0);
    drive(0, 1, 8'h55, 1);
    step();
    check("full pop no push rdy", int'(s_tready), 1);
    check("full pop no push head", int'(m_tdata), 8'hC1);
    check_cnt("full pop no push cnt", 3);
    drive(0, 1, 8'h55, 0);
    step();
    check("full accept 55 rdy", int'(s_tready), 0);
    check_cnt("full accept 55 cnt", 4);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("full drain%0d vld", i), int'(m_tvalid), 1);
      check($sformatf("full drain%0d data", i), int'(m_tdata),
            (i == 3) ? 8'h55 : 8'hC1 + i);
      drive(0, 0, 8'h00, 1);
      step();
    end
    check("full drained vld", int'(m_tvalid), 0);

    // Empty boundary: no bypass, word visible one edge after its push.
    check("empty before N vld", int'(m_tvalid), 0);
    drive(0, 1, 8'h77, 1);
    step();
    check("empty after N vld", int'(m_tvalid), 1);
    check("empty after N data", int'(m_tdata), 8'h77);
    drive(0, 0, 8'h00, 1);
    step();
    check("empty popped N+1 vld", int'(m_tvalid), 0);
    check_cnt("empty popped N+1 cnt", 0);

    // Reset in the middle of an active push with three words stored.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'(8'hD0 + i), 0);
      step();
    end
    check_cnt("midrst pre cnt", 3);
    drive(1, 1, 8'hD3, 0);
    step();
    check("midrst vld", int'(m_tvalid), 0);
    check("midrst rdy", int'(s_tready), 0);
    check_cnt("midrst cnt", 0);
    drive(0, 0, 8'h00, 0);
    step();
    check("midrst release rdy", int'(s_tready), 1);
    check("midrst release vld", int'(m_tvalid), 0);
    drive(0, 1, 8'hE0, 0);
    step();
    drive(0, 1, 8'hE1, 0);
    step();
    check_cnt("midrst repush cnt", 2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midrst drain%0d vld", i), int'(m_tvalid), 1);
      check($sformatf("midrst drain%0d data", i), int'(m_tdata), 8'hE0 + i);
      drive(0, 0, 8'h00, 1);
      step();
    end
    check("midrst drained vld", int'(m_tvalid), 0);

    // Random valid/ready against a queue model (FIFO currently empty).
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      sv_r = 1'($urandom_range(0, 1));
      mr_r = 1'($urandom_range(0, 1));
      d_r  = 8'($urandom_range(0, 255));
      check("rand s_tready", int'(s_tready), int'(q.size() < DEPTH));
      check("rand m_tvalid", int'(m_tvalid), int'(q.size() != 0));
      if (q.size() != 0) check("rand m_tdata", int'(m_tdata), int'(q[0]));
      check_cnt("rand m_tcount", q.size());
      do_push = sv_r && (q.size() < DEPTH);
      do_pop  = mr_r && (q.size() != 0);
      drive(0, sv_r, d_r, mr_r);
      step();
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d_r);
    end
    check("rand final m_tvalid", int'(m_tvalid), int'(q.size() != 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
